// File: rtl/id_ex_stage_register.sv
// Decode-to-execute pipeline register with load-use hazard bubbles, downstream stall hold and branch flush.
// Optional bubble counter is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 20,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  input  logic [DATA_WIDTH-1:0]     id_op_a,
  input  logic [DATA_WIDTH-1:0]     id_op_b,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      stall_in,
  input  logic                      flush,
  output logic                      ex_valid,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl,
  output logic [DATA_WIDTH-1:0]     ex_op_a,
  output logic [DATA_WIDTH-1:0]     ex_op_b,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      stall_out
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]               bubble_count
`endif
);

  localparam int LOAD_BIT = 16;
  localparam int WRE_BIT  = 15;

  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic load_bubble;

  // A load in EX that writes a register the decode slot reads must be separated by one bubble.
  always_comb begin
    rs1_match   = id_rs1_used && (id_rs1 == ex_rd);
    rs2_match   = id_rs2_used && (id_rs2 == ex_rd);
    hazard      = ex_valid && ex_ctrl[LOAD_BIT] && ex_ctrl[WRE_BIT] && id_valid &&
                  (ex_rd != '0) && (rs1_match || rs2_match);
    load_bubble = flush || (hazard && !stall_in);
  end

  assign stall_out = !rst && !flush && (hazard || stall_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (load_bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (!stall_in) begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_op_a  <= id_op_a;
      ex_op_b  <= id_op_b;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic bubble_event;

  // Only bubbles that displace a real instruction are counted; a flush of two empty slots is free.
  assign bubble_event = (flush && (ex_valid || id_valid)) || (!flush && hazard && !stall_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (bubble_event && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for id_ex_stage_register: the driver queues hand-derived expectations, a monitor checks ex_* after each edge.
// Counter checks are included when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage_register;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [19:0] id_ctrl;
  logic [31:0] id_op_a;
  logic [31:0] id_op_b;
  logic [31:0] id_imm;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [3:0]  id_rd;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        stall_in;
  logic        flush;
  logic        ex_valid;
  logic [19:0] ex_ctrl;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_imm;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic [3:0]  ex_rd;
  logic        stall_out;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_count;
`endif

  typedef struct {
    logic        v;
    logic [19:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        u1;
    logic        u2;
    logic        st;
    logic        fl;
  } vec_t;

  typedef struct {
    logic        v;
    logic [19:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  localparam int CAPTURE = 0;
  localparam int BUBBLE  = 1;
  localparam int HOLD    = 2;

  exp_t        scoreboard[$];
  exp_t        lastExp;
  logic [15:0] expCnt;
  int          errors;
  int          checks;

  id_ex_stage_register dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ctrl     (id_ctrl),
    .id_op_a     (id_op_a),
    .id_op_b     (id_op_b),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .stall_in    (stall_in),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ctrl     (ex_ctrl),
    .ex_op_a     (ex_op_a),
    .ex_op_b     (ex_op_b),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .stall_out   (stall_out)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic v, input logic [19:0] ctrl, input logic [31:0] a,
                                 input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                                 input logic u1, input logic u2, input logic st, input logic fl);
    vec_t r;
    r.v = v; r.ctrl = ctrl; r.a = a; r.b = a + 32'd1; r.imm = a + 32'd2;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.st = st; r.fl = fl;
    return r;
  endfunction

  function automatic exp_t zeroExp();
    exp_t e;
    e.v = 1'b0; e.ctrl = '0; e.a = '0; e.b = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.cnt = '0;
    return e;
  endfunction

  task automatic driveInputs(input vec_t vi);
    id_valid = vi.v; id_ctrl = vi.ctrl; id_op_a = vi.a; id_op_b = vi.b; id_imm = vi.imm;
    id_rs1 = vi.rs1; id_rs2 = vi.rs2; id_rd = vi.rd;
    id_rs1_used = vi.u1; id_rs2_used = vi.u2; stall_in = vi.st; flush = vi.fl;
  endtask

  // Drive one decode cycle, check the combinational stall, and queue what EX must hold after the edge.
  task automatic applyStimulus(input vec_t vi, input logic expStall, input int kind, input logic bub);
    exp_t e;
    @(negedge clk);
    driveInputs(vi);
    #1;
    checkOutput("stall_out", {31'd0, stall_out}, {31'd0, expStall});
    if (bub && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
    case (kind)
      CAPTURE: begin
        e.v = vi.v; e.ctrl = vi.v ? vi.ctrl : 20'h0; e.a = vi.a; e.b = vi.b; e.imm = vi.imm;
        e.rs1 = vi.rs1; e.rs2 = vi.rs2; e.rd = vi.rd;
      end
      BUBBLE:  e = zeroExp();
      default: e = lastExp;
    endcase
    e.cnt = expCnt;
    lastExp = e;
    scoreboard.push_back(e);
  endtask

  task automatic finishRun();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Monitor: compare the EX slot one step after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        checkOutput("ex_ctrl", {12'd0, ex_ctrl}, {12'd0, e.ctrl});
        checkOutput("ex_op_a", ex_op_a, e.a);
        checkOutput("ex_op_b", ex_op_b, e.b);
        checkOutput("ex_imm", ex_imm, e.imm);
        checkOutput("ex_rs1", {28'd0, ex_rs1}, {28'd0, e.rs1});
        checkOutput("ex_rs2", {28'd0, ex_rs2}, {28'd0, e.rs2});
        checkOutput("ex_rd", {28'd0, ex_rd}, {28'd0, e.rd});
`ifdef ID_EX_BUBBLE_CNT_EN
        checkOutput("bubble_count", {16'd0, bubble_count}, {16'd0, e.cnt});
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog actual=timeout expected=completion");
    finishRun();
  end

  initial begin
    errors  = 0;
    checks  = 0;
    expCnt  = '0;
    lastExp = zeroExp();
    rst     = 1'b1;
    driveInputs(mkVec(1'b0, 20'h0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2;
    checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_ex_ctrl", {12'd0, ex_ctrl}, 32'd0);
    checkOutput("reset_stall_out", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through, then load followed by a dependent instruction.
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h5,  4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'h10, 4'd1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h20, 4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, BUBBLE,  1'b1);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h20, 4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);

    // No false hazards: load to r0, reads of r0, unused source, invalid decode slot.
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'h30, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h40, 4'd0, 4'd3, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'h50, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h60, 4'd7, 4'd2, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'h70, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b0, 20'h0_8012, 32'h80, 4'd0, 4'd9, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);

    // Downstream stall for three cycles with changing decode inputs.
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h90, 4'd1, 4'd2, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_4005, 32'hA0, 4'd3, 4'd4, 4'd12, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, HOLD,    1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_2006, 32'hB0, 4'd5, 4'd6, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, HOLD,    1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_1007, 32'hC0, 4'd7, 4'd8, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, HOLD,    1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'hD0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);

    // Hazard under stall_in is deferred until the stall drops.
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'hE0, 4'd1, 4'd2, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'hE8, 4'd12, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, HOLD,    1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'hE8, 4'd12, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, BUBBLE,  1'b1);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'hE8, 4'd12, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);

    // Flush beats hazard and stall_in; flushing two empty slots is not a counted bubble.
    applyStimulus(mkVec(1'b1, 20'h1_8400, 32'hF0, 4'd1, 4'd2, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'hF8, 4'd13, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0, BUBBLE,  1'b1);
    applyStimulus(mkVec(1'b0, 20'h0_8012, 32'hFC, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, BUBBLE,  1'b0);

    // Asynchronous reset mid-cycle while a load sits in EX and a dependent stalled instruction waits.
    applyStimulus(mkVec(1'b1, 20'h1_8011, 32'h123, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);
    @(posedge clk);
    #3;
    driveInputs(mkVec(1'b1, 20'h0_8012, 32'h200, 4'd5, 4'd2, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0));
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("async_rst_ex_ctrl", {12'd0, ex_ctrl}, 32'd0);
    checkOutput("async_rst_ex_op_a", ex_op_a, 32'd0);
    checkOutput("async_rst_ex_rd", {28'd0, ex_rd}, 32'd0);
    checkOutput("async_rst_stall_out", {31'd0, stall_out}, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkOutput("async_rst_bubble_count", {16'd0, bubble_count}, 32'd0);
`endif
    expCnt  = '0;
    lastExp = zeroExp();
    driveInputs(mkVec(1'b0, 20'h0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h200, 4'd5, 4'd2, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, CAPTURE, 1'b0);

`ifdef ID_EX_BUBBLE_CNT_EN
    // Drive 65535 counted flushes to reach the ceiling, then one more must not wrap.
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      driveInputs(mkVec(1'b1, 20'h0_8012, 32'h300, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    @(posedge clk);
    #1;
    checkOutput("bubble_count_full", {16'd0, bubble_count}, 32'h0000_FFFF);
    expCnt = 16'hFFFF;
    applyStimulus(mkVec(1'b1, 20'h0_8012, 32'h310, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, BUBBLE, 1'b1);
`endif

    repeat (2) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", scoreboard.size(), 32'd0);
    finishRun();
  end

endmodule
